mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 16, meaning maximum BUSY cycles before abort; legal range 1..255.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have ports req0/req1  input  1  per-port request; port 0 is the fetch side, port 1 is the data side.
REQ-007 The block SHALL have ports addr0/addr1  input  ADDR_W, we0/we1  input  1, and wdata0/wdata1  input  DATA_W, meaning per-port access fields.
REQ-008 The block SHALL have ports done0/done1  output  1  per-port completion pulse.
REQ-009 The block SHALL have port rdata  output  DATA_W  read data, valid while done0 or done1 is high.
REQ-010 The block SHALL have port err  output  1  timeout flag, valid only together with a done pulse.
REQ-011 The block SHALL have port sel  output  1  current owner: 0 for port 0, 1 for port 1; drives the external mux2_1 select of the shared memory path.
REQ-012 The block SHALL have ports mem_req  output  1, mem_addr  output  ADDR_W, mem_we  output  1, and mem_wdata  output  DATA_W, meaning the memory-side request.
REQ-013 The block SHALL have ports mem_ready  input  1 and mem_rdata  input  DATA_W, meaning memory completion and read data.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY, RESP.
REQ-015 In IDLE with no request, the state SHALL remain IDLE with mem_req=0.
REQ-016 In IDLE with exactly one reqN high, that port SHALL be granted.
REQ-017 In IDLE with both requests high, the port not equal to last_owner SHALL be granted (round-robin).
REQ-018 On grant, the block SHALL register sel and the granted port's addr, we and wdata, then enter BUSY on the same edge.
REQ-019 In BUSY, mem_req SHALL be 1 and mem_addr/mem_we/mem_wdata SHALL hold the registered values, stable until exit.
REQ-020 Requester inputs SHALL be ignored outside IDLE, including withdrawal of req mid-transaction; the transaction SHALL complete regardless.
REQ-021 A BUSY-cycle counter SHALL clear on BUSY entry and increment each BUSY cycle without mem_ready.
REQ-022 In BUSY with mem_ready=1, the block SHALL capture mem_rdata into rdata, set err=0, and enter RESP.
REQ-023 In BUSY, if the counter reaches TIMEOUT without mem_ready, the block SHALL set err=1 and rdata=0, and enter RESP.
REQ-024 If mem_ready=1 coincides with the TIMEOUT cycle, mem_ready SHALL win and err SHALL be 0.
REQ-025 In RESP, done[sel] SHALL be 1 for exactly one cycle, mem_req SHALL be 0, last_owner SHALL update to sel, and the next state SHALL be IDLE.
REQ-026 Requesters SHALL drop req on the edge at which they observe done; a req still high in IDLE SHALL be treated as a new request.
REQ-027 Minimum latency SHALL be: req seen at edge k, mem_req high in cycle k+1; mem_ready at cycle m, done high in cycle m+1; 3 cycles total with zero-wait memory.
REQ-028 Every mem_req assertion SHALL run ≥1 cycle and end only on mem_ready or timeout; done0 and done1 SHALL never both be high.
REQ-029 In IDLE and RESP, sel SHALL hold its last value.

Reset
REQ-030 On reset=1 at a clock edge, state SHALL become IDLE; mem_req, done0, done1 and err SHALL become 0; sel SHALL become 0; last_owner SHALL become 1, so port 0 wins the first contention; rdata, the registered memory outputs and the counter SHALL become 0.
REQ-031 Reset asserted in BUSY or RESP SHALL abort the transaction with no done pulse; mem_req SHALL be 0 in the cycle after the reset edge.

Verification
REQ-032 Single port 0 read: req0=1, addr0=0x100, mem_ready=1 one cycle after mem_req with mem_rdata=0xCAFE -> mem_addr=0x100, mem_we=0, sel=0, done0 pulse with rdata=0xCAFE, err=0.
REQ-033 Contention after reset: req0 and req1 both high continuously -> grants alternate 0,1,0,1, each with one done pulse; done1 with mem_we=1 and mem_wdata=wdata1 when we1=1.
REQ-034 Wait states: mem_ready delayed 5 cycles -> mem_req high 5 cycles, mem_addr and sel stable throughout, done exactly 1 cycle after mem_ready.
REQ-035 Timeout: TIMEOUT=4, mem_ready held 0 -> RESP after 4 BUSY cycles, done pulse with err=1 and rdata=0; mem_ready in 4th cycle -> err=0.
REQ-036 Reset mid-BUSY: reset pulsed 2 cycles into BUSY -> mem_req=0 next cycle, no done; next contention grants port 0.
REQ-037 Request withdrawal: req1 dropped during BUSY -> transaction completes and done1 still pulses.

Source files
------------

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Two-port round-robin arbiter in front of a single shared memory path.
// Port 0 is the instruction-fetch side, port 1 the data side. One
// transaction is in flight at a time; the owner's request fields are
// captured at grant and held on the memory side until the memory answers
// (mem_ready) or the BUSY-cycle budget (TIMEOUT) runs out.
//
// Parameters
//   ADDR_W   address width
//   DATA_W   data width
//   TIMEOUT  maximum BUSY cycles before the access is aborted (1..255)
//
// Ports
//   clk, reset                single clock, synchronous active-high reset
//   req0/req1                 per-port request
//   addr0/1, we0/1, wdata0/1  per-port access fields, sampled only at grant
//   done0/done1               one-cycle completion pulse for the owner
//   rdata                     read data, valid with a done pulse
//   err                       timeout flag, valid with a done pulse
//   sel                       current owner, drives the external mux select
//   mem_req, mem_addr,
//   mem_we, mem_wdata         memory-side request, stable while mem_req=1
//   mem_ready, mem_rdata      memory completion and read data
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              sel,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter is 8 bits wide because TIMEOUT is bounded to 255.
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

  state_t              state_q, state_d;
  logic                sel_q, sel_d;
  logic                last_owner_q, last_owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                mem_req_q, mem_req_d;
  logic                done0_q, done0_d;
  logic                done1_q, done1_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [7:0]          cnt_inc;
  logic                gnt;

  // Round-robin pick: a lone requester always wins; under contention the
  // port that did not own the previous transaction wins.
  function automatic logic rr_pick(input logic r0, input logic r1,
                                   input logic last);
    if (r0 && r1) begin
      return ~last;
    end
    return r1;
  endfunction

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    mem_req_d    = mem_req_q;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err_d        = err_q;
    rdata_d      = rdata_q;
    cnt_d        = cnt_q;
    gnt          = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt       = rr_pick(req0, req1, last_owner_q);
          sel_d     = gnt;
          addr_d    = gnt ? addr1  : addr0;
          we_d      = gnt ? we1    : we0;
          wdata_d   = gnt ? wdata1 : wdata0;
          cnt_d     = 8'd0;
          mem_req_d = 1'b1;
          state_d   = BUSY;
        end
      end

      BUSY: begin
        // mem_ready is tested first so it wins over a coincident timeout.
        if (mem_ready) begin
          rdata_d   = mem_rdata;
          err_d     = 1'b0;
          mem_req_d = 1'b0;
          done0_d   = ~sel_q;
          done1_d   = sel_q;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_LIM) begin
            rdata_d   = '0;
            err_d     = 1'b1;
            mem_req_d = 1'b0;
            done0_d   = ~sel_q;
            done1_d   = sel_q;
            state_d   = RESP;
          end
        end
      end

      RESP: begin
        last_owner_d = sel_q;
        state_d      = IDLE;
      end

      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= 1'b0;
      // Reset as if port 1 owned last, so port 0 wins the first contention.
      last_owner_q <= 1'b1;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      mem_req_q    <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      cnt_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      mem_req_q    <= mem_req_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      cnt_q        <= cnt_d;
    end
  end

  assign done0     = done0_q;
  assign done1     = done1_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign sel       = sel_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;

endmodule
